// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: the host loads a program into the instruction RAM.
// On start, words are prefetched from start_addr into a small FWFT queue.
// Fetching stops at the first END-opcode word. The chain completes when that
// END word is consumed.
module instr_fetch_queue #(
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter int unsigned MEM_AWIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned OPCODE_WIDTH = 5,
  parameter logic [OPCODE_WIDTH-1:0] END_OPCODE = 5'h1F
) (
  input  logic                          clk,
  input  logic                          reset_npu_n,
  input  logic                          push_instr_enable,
  input  logic [MEM_AWIDTH-1:0]         push_instr_addr,
  input  logic [INSTR_WIDTH-1:0]        push_instruction,
  input  logic                          start,
  input  logic [MEM_AWIDTH-1:0]         start_addr,
  input  logic                          flush,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [INSTR_WIDTH-1:0]        instruction,
  output logic [MEM_AWIDTH-1:0]         instr_addr,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned MemDepth = 2 ** MEM_AWIDTH;
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [INSTR_WIDTH-1:0]  r_mem [MemDepth];
  logic [INSTR_WIDTH-1:0]  r_rd_data;
  logic [MEM_AWIDTH-1:0]   r_rd_addr;
  logic [MEM_AWIDTH-1:0]   r_pc;
  logic                    r_inflight;
  logic [INSTR_WIDTH-1:0]  r_q_data [FIFO_DEPTH];
  logic [MEM_AWIDTH-1:0]   r_q_addr [FIFO_DEPTH];
  logic [PtrW-1:0]         r_wptr;
  logic [PtrW-1:0]         r_rptr;
  logic [CntW-1:0]         r_count;

  logic                    w_start;
  logic                    w_flush;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_issue;
  logic                    w_ret_end;
  logic                    w_head_end;
  logic [INSTR_WIDTH-1:0]  w_head;
  logic [CntW:0]           w_occ;

  // Flush only matters once a chain is running; in IDLE it also blocks start.
  assign w_start    = (r_state == StIdle) & start & ~flush;
  assign w_flush    = (r_state != StIdle) & flush;

  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid & instr_ready;
  assign w_head      = r_q_data[r_rptr];
  assign w_head_end  = (w_head[INSTR_WIDTH-1 -: OPCODE_WIDTH] == END_OPCODE);
  assign w_ret_end   = r_inflight & (r_rd_data[INSTR_WIDTH-1 -: OPCODE_WIDTH] == END_OPCODE);

  // Returned words are only kept while fetching; anything arriving in DRAIN is stale.
  assign w_push  = r_inflight & (r_state == StFetch) & ~flush;
  // Occupancy after this cycle counting the word already on its way back.
  assign w_occ   = {1'b0, r_count} + (CntW + 1)'(r_inflight) - (CntW + 1)'(w_pop);
  assign w_issue = (r_state == StFetch) & ~flush & ~w_ret_end & (w_occ < DepthOcc);

  assign busy        = (r_state != StIdle);
  assign fifo_count  = r_count;
  assign instruction = instr_valid ? w_head : '0;
  assign instr_addr  = instr_valid ? r_q_addr[r_rptr] : '0;

  // Instruction RAM: host write port plus registered read; no reset so the program survives.
  always_ff @(posedge clk) begin
    if (push_instr_enable) begin
      r_mem[push_instr_addr] <= push_instruction;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[r_pc];
      r_rd_addr <= r_pc;
    end
  end

  // Queue storage: returned word and its address land at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wptr] <= r_rd_data;
      r_q_addr[r_wptr] <= r_rd_addr;
    end
  end

  // Queue pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or negedge reset_npu_n) begin
    if (!reset_npu_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // State, program counter and in-flight read tracking.
  always_ff @(posedge clk or negedge reset_npu_n) begin
    if (!reset_npu_n) begin
      r_state    <= StIdle;
      r_pc       <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      if (w_start) begin
        r_pc <= start_addr;
      end else if (w_issue) begin
        r_pc <= r_pc + MEM_AWIDTH'(1);
      end
    end
  end

  // Next-state decode and the done pulse on consuming the END word.
  always_comb begin
    w_state_next = r_state;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = StFetch;
        end
      end
      StFetch: begin
        if (flush) begin
          w_state_next = StIdle;
        end else if (w_push && w_ret_end) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (flush) begin
          w_state_next = StIdle;
        end else if (w_pop && w_head_end) begin
          w_state_next = StIdle;
          done         = 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

endmodule
